// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared definitions for the PPU VRAM controller slice:
//   region_e    - 14-bit PPU address region (pattern / nametable / palette)
//   wtoggle_e   - PPUADDR write toggle (first / second byte)
//   NT_BASE, PAL_BASE, ADDR_MAX - address map boundaries
//   REG_PPUADDR, REG_PPUDATA    - CPU register select codes
// ---------------------------------------------------------------------------
package ppu_pkg;

    typedef enum logic [1:0] {
        PT  = 2'd0,
        NT  = 2'd1,
        PAL = 2'd2
    } region_e;

    typedef enum logic {
        W_FIRST  = 1'b0,
        W_SECOND = 1'b1
    } wtoggle_e;

    localparam logic [13:0] NT_BASE  = 14'h2000;
    localparam logic [13:0] PAL_BASE = 14'h3F00;
    localparam logic [13:0] ADDR_MAX = 14'h3FFF;

    localparam logic [2:0] REG_PPUADDR = 3'd6;
    localparam logic [2:0] REG_PPUDATA = 3'd7;

endpackage

// File: rtl/ppu_vram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ppu_vram_ctrl_if
// CPU-side register bus of the PPU VRAM controller.
//   cpu_cs    - single-cycle register access strobe
//   cpu_we    - 1 = write, 0 = read (qualified by cpu_cs)
//   cpu_reg   - register select (6 = PPUADDR, 7 = PPUDATA)
//   cpu_din   - write data
//   cpu_dout  - read data (0x00 unless a PPUDATA read is active)
//   inc32     - PPUCTRL bit 2: PPUDATA step of 32 instead of 1
//   latch_clr - PPUSTATUS read pulse, restarts the PPUADDR write toggle
// master = CPU side, slave = controller side.
// ---------------------------------------------------------------------------
interface ppu_vram_ctrl_if;
    logic       cpu_cs;
    logic       cpu_we;
    logic [2:0] cpu_reg;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       inc32;
    logic       latch_clr;

    modport master (
        output cpu_cs, cpu_we, cpu_reg, cpu_din, inc32, latch_clr,
        input  cpu_dout
    );

    modport slave (
        input  cpu_cs, cpu_we, cpu_reg, cpu_din, inc32, latch_clr,
        output cpu_dout
    );
endinterface

// File: rtl/ppu_addr_decode.sv
// ---------------------------------------------------------------------------
// ppu_addr_decode
// Combinational PPU address decode: region, mirrored CIRAM index and
// aliased palette index for a 14-bit PPU address.
//   addr_i     - 14-bit PPU address
//   region_o   - PT / NT / PAL
//   nt_idx_o   - 11-bit CIRAM index after nametable mirroring
//   pal_idx_o  - 5-bit palette entry after backdrop aliasing
// ---------------------------------------------------------------------------
module ppu_addr_decode
    import ppu_pkg::*;
#(
    parameter bit MIRROR_VERTICAL = 1'b1
) (
    input  logic [13:0] addr_i,
    output region_e     region_o,
    output logic [10:0] nt_idx_o,
    output logic [4:0]  pal_idx_o
);

    always_comb begin
        if (addr_i < NT_BASE) begin
            region_o = PT;
        end else if (addr_i >= PAL_BASE) begin
            region_o = PAL;
        end else begin
            region_o = NT;
        end
    end

    // Vertical mirroring selects the page with A10, horizontal with A11.
    // 0x3000-0x3EFF falls out as an alias because A12 is never looked at.
    assign nt_idx_o = {(MIRROR_VERTICAL ? addr_i[10] : addr_i[11]), addr_i[9:0]};

    // Sprite backdrop slots (x0, x4, x8, xC in the upper half) share the
    // background backdrop entries.
    assign pal_idx_o = {addr_i[4] & (addr_i[1:0] != 2'b00), addr_i[3:0]};

endmodule

// File: rtl/ppu_vram_ctrl.sv
// ---------------------------------------------------------------------------
// ppu_vram_ctrl
// PPU VRAM controller: 2 KB nametable CIRAM, 32 x 6 palette RAM, PPUADDR /
// PPUDATA register handling for the CPU and a stall-free renderer read port.
//   clk, reset          - clock, asynchronous active-high reset
//   r_addr / r_data     - renderer read port (zero-cycle latency)
//   pal_idx / pal_color - renderer palette lookup
//   cpu                 - CPU register bus (ppu_vram_ctrl_if.slave)
//   chr_addr / chr_data - external pattern ROM (combinational data)
// ---------------------------------------------------------------------------
module ppu_vram_ctrl
    import ppu_pkg::*;
#(
    parameter bit MIRROR_VERTICAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           r_addr,
    output logic [7:0]            r_data,
    input  logic [4:0]            pal_idx,
    output logic [5:0]            pal_color,
    ppu_vram_ctrl_if.slave        cpu,
    output logic [12:0]           chr_addr,
    input  logic [7:0]            chr_data
);

    logic [7:0]  ciram_q [2048];
    logic [5:0]  pal_q   [32];

    wtoggle_e    w_q, w_d;
    logic [13:0] v_q, v_d;
    logic [5:0]  t_hi_q, t_hi_d;
    logic [7:0]  rbuf_q, rbuf_d;
    logic        ciram_we, pal_we;
    logic [7:0]  cpu_dout;
    logic [13:0] v_inc;

    region_e     r_rgn, c_rgn;
    logic [10:0] r_nt, c_nt;
    logic [4:0]  r_pal, c_pal;

    logic        unused_r_addr_hi;
    assign unused_r_addr_hi = ^r_addr[15:14];

    ppu_addr_decode #(.MIRROR_VERTICAL(MIRROR_VERTICAL)) u_dec_render (
        .addr_i    (r_addr[13:0]),
        .region_o  (r_rgn),
        .nt_idx_o  (r_nt),
        .pal_idx_o (r_pal)
    );

    ppu_addr_decode #(.MIRROR_VERTICAL(MIRROR_VERTICAL)) u_dec_cpu (
        .addr_i    (v_q),
        .region_o  (c_rgn),
        .nt_idx_o  (c_nt),
        .pal_idx_o (c_pal)
    );

    // Renderer port: pure combinational lookups, never blocked by the CPU.
    always_comb begin
        case (r_rgn)
            PT:      r_data = chr_data;
            NT:      r_data = ciram_q[r_nt];
            default: r_data = {2'b00, pal_q[r_pal]};
        endcase
    end

    assign pal_color = pal_q[(pal_idx[1:0] == 2'b00) ? 5'd0 : pal_idx];
    assign chr_addr  = (r_rgn == PT) ? r_addr[12:0] : v_q[12:0];

    assign v_inc = (v_q + (cpu.inc32 ? 14'd32 : 14'd1)) & ADDR_MAX;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q    <= W_FIRST;
            v_q    <= '0;
            t_hi_q <= '0;
            rbuf_q <= '0;
        end else begin
            w_q    <= w_d;
            v_q    <= v_d;
            t_hi_q <= t_hi_d;
            rbuf_q <= rbuf_d;
        end
    end

    always_comb begin
        w_d      = w_q;
        v_d      = v_q;
        t_hi_d   = t_hi_q;
        rbuf_d   = rbuf_q;
        ciram_we = 1'b0;
        pal_we   = 1'b0;
        cpu_dout = 8'h00;

        if (cpu.cpu_cs) begin
            if (cpu.cpu_reg == REG_PPUADDR && cpu.cpu_we) begin
                if (w_q == W_FIRST) begin
                    t_hi_d = cpu.cpu_din[5:0];
                    w_d    = W_SECOND;
                end else begin
                    v_d = {t_hi_q, cpu.cpu_din};
                    w_d = W_FIRST;
                end
            end else if (cpu.cpu_reg == REG_PPUDATA) begin
                v_d = v_inc;
                if (cpu.cpu_we) begin
                    ciram_we = (c_rgn == NT);
                    pal_we   = (c_rgn == PAL);
                end else if (c_rgn == PAL) begin
                    // v - 0x1000 only clears A12, which the nametable decode
                    // ignores, so c_nt already points at the shadowed byte.
                    cpu_dout = {2'b00, pal_q[c_pal]};
                    rbuf_d   = ciram_q[c_nt];
                end else begin
                    cpu_dout = rbuf_q;
                    rbuf_d   = (c_rgn == PT) ? chr_data : ciram_q[c_nt];
                end
            end
        end

        // Toggle restart wins over whatever the same-cycle write did to W.
        if (cpu.latch_clr) begin
            w_d = W_FIRST;
        end
    end

    assign cpu.cpu_dout = cpu_dout;

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (ciram_we) begin
            ciram_q[c_nt] <= cpu.cpu_din;
        end
        if (pal_we) begin
            pal_q[c_pal] <= cpu.cpu_din[5:0];
        end
    end

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ppu_vram_ctrl
// Directed bench for ppu_vram_ctrl with hand-computed expected values.
// The pattern ROM model returns chr_addr[7:0] ^ 8'h5A.
// ---------------------------------------------------------------------------
module tb_ppu_vram_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic [4:0]  pal_idx;
    logic [5:0]  pal_color;
    logic [12:0] chr_addr;
    logic [7:0]  chr_data;

    int n_tests;
    int n_fail;

    ppu_vram_ctrl_if bus ();

    ppu_vram_ctrl #(.MIRROR_VERTICAL(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .pal_idx   (pal_idx),
        .pal_color (pal_color),
        .cpu       (bus),
        .chr_addr  (chr_addr),
        .chr_data  (chr_data)
    );

    assign chr_data = chr_addr[7:0] ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_acc(input logic we, input logic [2:0] rg, input logic [7:0] d,
                           input logic clr, output logic [7:0] q);
        @(negedge clk);
        bus.cpu_cs    = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_reg   = rg;
        bus.cpu_din   = d;
        bus.latch_clr = clr;
        #1 q = bus.cpu_dout;
        @(posedge clk);
        #1;
        bus.cpu_cs    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.latch_clr = 1'b0;
    endtask

    task automatic wr(input logic [2:0] rg, input logic [7:0] d);
        logic [7:0] dummy;
        cpu_acc(1'b1, rg, d, 1'b0, dummy);
    endtask

    task automatic wr_clr(input logic [7:0] d);
        logic [7:0] dummy;
        cpu_acc(1'b1, 3'd6, d, 1'b1, dummy);
    endtask

    task automatic rd(output logic [7:0] q);
        cpu_acc(1'b0, 3'd7, 8'h00, 1'b0, q);
    endtask

    // Observe v[12:0] through chr_addr while the renderer is off pattern space.
    task automatic check_v(input string tag, input logic [12:0] exp);
        r_addr = 16'h2000;
        #1 check_val(tag, {3'b0, chr_addr}, {3'b0, exp});
    endtask

    task automatic check_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        r_addr = a;
        #1 check_val(tag, {8'h00, r_data}, {8'h00, exp});
    endtask

    task automatic check_pal(input string tag, input logic [4:0] idx, input logic [5:0] exp);
        pal_idx = idx;
        #1 check_val(tag, {10'h000, pal_color}, {10'h000, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q;
        n_tests = 0;
        n_fail  = 0;
        reset         = 1'b1;
        bus.cpu_cs    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_reg   = 3'd0;
        bus.cpu_din   = 8'h00;
        bus.inc32     = 1'b0;
        bus.latch_clr = 1'b0;
        r_addr        = 16'h2000;
        pal_idx       = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and pattern pass-through.
        check_v("rst_v", 13'h0000);
        check_val("rst_cpu_dout", {8'h00, bus.cpu_dout}, 16'h0000);
        r_addr = 16'h0123;
        #1 check_val("pt_chr_addr", {3'b0, chr_addr}, 16'h0123);
        check_rd("pt_r_data", 16'h0123, 8'h79);

        // Nametable writes with +1 step and vertical mirroring.
        wr(3'd6, 8'h21); wr(3'd6, 8'h08);
        wr(3'd7, 8'hAA); wr(3'd7, 8'hBB);
        check_rd("nt_2108", 16'h2108, 8'hAA);
        check_rd("nt_2109", 16'h2109, 8'hBB);
        check_rd("nt_mirror_2908", 16'h2908, 8'hAA);
        check_rd("nt_alias_3108", 16'h3108, 8'hAA);
        check_v("v_after_wr", 13'h010A);

        // Buffered PPUDATA reads.
        wr(3'd6, 8'h21); wr(3'd6, 8'h08);
        rd(q); check_val("rd_stale", {8'h00, q}, 16'h0000);
        rd(q); check_val("rd_2108", {8'h00, q}, 16'h00AA);
        rd(q); check_val("rd_2109", {8'h00, q}, 16'h00BB);

        // Other register selects are ignored.
        wr(3'd6, 8'h21); wr(3'd5, 8'h30); wr(3'd6, 8'h40);
        check_v("reg5_ignored", 13'h0140);

        // Old value visible during the write cycle, new value after the edge.
        wr(3'd6, 8'h21); wr(3'd6, 8'h08);
        @(negedge clk);
        bus.cpu_cs  = 1'b1;
        bus.cpu_we  = 1'b1;
        bus.cpu_reg = 3'd7;
        bus.cpu_din = 8'hCC;
        r_addr      = 16'h2108;
        #1 check_val("wr_cycle_old", {8'h00, r_data}, 16'h00AA);
        @(posedge clk);
        #1;
        bus.cpu_cs = 1'b0;
        bus.cpu_we = 1'b0;
        check_val("wr_cycle_new", {8'h00, r_data}, 16'h00CC);

        // Palette writes and aliasing.
        wr(3'd6, 8'h3F); wr(3'd6, 8'h10); wr(3'd7, 8'h2C);
        check_pal("pal_idx00", 5'h00, 6'h2C);
        check_rd("pal_r_3F00", 16'h3F00, 8'h2C);
        check_rd("pal_r_3F10", 16'h3F10, 8'h2C);
        wr(3'd6, 8'h3F); wr(3'd6, 8'h04); wr(3'd7, 8'h15); wr(3'd7, 8'hFF);
        check_rd("pal_alias_3F14", 16'h3F14, 8'h15);
        // Renderer lookups with low bits 00 always land on the backdrop.
        check_pal("pal_idx14_backdrop", 5'h14, 6'h2C);
        check_pal("pal_idx05_trunc", 5'h05, 6'h3F);
        check_rd("pal_r_3F05", 16'h3F05, 8'h3F);

        // Palette read: direct data, buffer filled from the nametable below.
        wr(3'd6, 8'h2F); wr(3'd6, 8'h05); wr(3'd7, 8'h77);
        wr(3'd6, 8'h3F); wr(3'd6, 8'h05);
        rd(q); check_val("pal_rd_direct", {8'h00, q}, 16'h003F);
        wr(3'd6, 8'h21); wr(3'd6, 8'h08);
        rd(q); check_val("pal_rd_buf", {8'h00, q}, 16'h0077);

        // +32 step wrapping past 0x3FFF; pattern-space writes are dropped.
        bus.inc32 = 1'b1;
        wr(3'd6, 8'h3F); wr(3'd6, 8'hF0); wr(3'd7, 8'h11);
        check_v("wrap_v", 13'h0010);
        check_pal("wrap_pal_wr", 5'h00, 6'h11);
        wr(3'd7, 8'h99);
        check_rd("pt_wr_ignored", 16'h0010, 8'h4A);
        check_rd("pt_wr_nt_intact", 16'h2108, 8'hCC);
        check_v("v_step32", 13'h0030);
        bus.inc32 = 1'b0;

        // Toggle restart by latch_clr between writes.
        wr(3'd6, 8'h23);
        @(negedge clk);
        bus.latch_clr = 1'b1;
        @(posedge clk);
        #1 bus.latch_clr = 1'b0;
        wr(3'd6, 8'h20); wr(3'd6, 8'h00);
        check_v("latch_restart", 13'h0000);
        wr(3'd7, 8'h5E);
        check_rd("latch_wr_2000", 16'h2000, 8'h5E);

        // latch_clr together with a first-byte write: byte taken, toggle restarted.
        wr_clr(8'h3F);
        wr(3'd6, 8'h21); wr(3'd6, 8'h44);
        check_v("latch_same_first", 13'h0144);
        // latch_clr together with a second-byte write: v loads, toggle at FIRST.
        wr(3'd6, 8'h21); wr_clr(8'h50);
        check_v("latch_same_second", 13'h0150);
        wr(3'd6, 8'h22); wr(3'd6, 8'h00);
        check_v("latch_same_after", 13'h0200);

        // Reset between PPUADDR bytes discards the high byte.
        wr(3'd6, 8'h25);
        r_addr = 16'h2000;
        reset  = 1'b1;
        #2 check_val("rst_mid_v", {3'b0, chr_addr}, 16'h0000);
        #1 reset = 1'b0;
        wr(3'd6, 8'h21); wr(3'd6, 8'h08);
        check_v("rst_mid_hi_byte", 13'h0108);
        rd(q); check_val("rst_rbuf", {8'h00, q}, 16'h0000);
        check_rd("rst_ram_kept", 16'h2108, 8'hCC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
